// File: rtl/latch_bank_arbiter.sv
// Round-robin arbitrated write port into a small register bank with a combinational read port.
// Optional LBA_STATS_EN adds a saturating commit counter on wr_count.
module latch_bank_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] wr_addr,
  input  logic [NREQ*DW-1:0] wr_data,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    ack,
  input  logic [AW-1:0]      rd_addr,
  output logic [DW-1:0]      rd_data,
  output logic               busy
`ifdef LBA_STATS_EN
  ,
  output logic [7:0]         wr_count
`endif
);

  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NENT = 2 ** AW;

  typedef enum logic [1:0] {StIdle, StGrant, StCommit} state_e;

  state_e        state_q;
  logic [IW-1:0] winner_q;
  logic [IW-1:0] rr_ptr_q;
  logic [DW-1:0] bank_q [NENT];
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic [IW-1:0] rr_next;

  // Walk offsets from high to low so the lowest offset from rr_ptr wins.
  always_comb begin
    pick = rr_ptr_q;
    cand = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      cand = IW'((int'(rr_ptr_q) + i) % int'(NREQ));
      if (req[cand]) pick = cand;
    end
  end

  assign rr_next = (winner_q == IW'(NREQ - 1)) ? '0 : winner_q + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      winner_q <= '0;
      rr_ptr_q <= '0;
      for (int i = 0; i < int'(NENT); i++) bank_q[i] <= '0;
`ifdef LBA_STATS_EN
      wr_count <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            winner_q <= pick;
            state_q  <= StGrant;
          end
        end
        StGrant: begin
          // A requester that let go during GRANT forfeits its slot without moving rr_ptr.
          if (req[winner_q]) begin
            bank_q[wr_addr[winner_q*AW +: AW]] <= wr_data[winner_q*DW +: DW];
            state_q <= StCommit;
          end else begin
            state_q <= StIdle;
          end
        end
        StCommit: begin
          rr_ptr_q <= rr_next;
          state_q  <= StIdle;
`ifdef LBA_STATS_EN
          if (wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    grant = '0;
    ack   = '0;
    if (state_q == StGrant)  grant[winner_q] = 1'b1;
    if (state_q == StCommit) ack[winner_q]   = 1'b1;
  end

  assign busy    = (state_q != StIdle);
  assign rd_data = bank_q[rd_addr];

endmodule

// File: doc/latch_bank_arbiter.md
LATCH_BANK_ARBITER -- requirements
Module: latch_bank_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-high.
REQ-002 Parameters SHALL be (name, default, meaning):
- NREQ, 4, number of requesters.
- DW, 8, entry data width.
- AW, 2, entry address width; 2**AW entries.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- rst, in, 1, async active-high reset.
- req, in, NREQ, per-requester write request.
- wr_addr, in, NREQ*AW, requester i address at bits [i*AW +: AW].
- wr_data, in, NREQ*DW, requester i data at bits [i*DW +: DW].
- grant, out, NREQ, one-hot grant.
- ack, out, NREQ, one-hot write-done pulse.
- rd_addr, in, AW, read address.
- rd_data, out, DW, bank[rd_addr], combinational.
- busy, out, 1, high when state is not IDLE.
- wr_count, out, 8, saturating commit counter (LBA_STATS_EN only).

Function
REQ-004 The block SHALL own a register bank of 2**AW entries of DW bits, written only through the arbiter.
REQ-005 The FSM SHALL have states IDLE, GRANT and COMMIT, each Moore-decoded from registered state and the registered winner index.
REQ-006 IDLE transitions:
- any req high -> GRANT, with winner = first requester with req high, searching upward from rr_ptr with wrap NREQ-1 -> 0.
- otherwise stay in IDLE.
REQ-007 In GRANT, grant[winner] SHALL be 1 for exactly one cycle; all other grant bits SHALL be 0.
REQ-008 At the edge ending GRANT, if req[winner] is still 1:
- bank[wr_addr(winner)] <= wr_data(winner);
- next state = COMMIT.
REQ-009 At the edge ending GRANT, if req[winner] has dropped to 0:
- no write occurs;
- no ack is issued;
- next state = IDLE;
- rr_ptr is unchanged.
REQ-010 In COMMIT, ack[winner] SHALL be 1 for exactly one cycle; at the edge ending COMMIT, rr_ptr <= (winner+1) mod NREQ and next state = IDLE.
REQ-011 Latency SHALL be fixed: req sampled high in IDLE at edge k gives grant in cycle k..k+1, bank updated at edge k+1, ack in cycle k+1..k+2; one write per 3 cycles maximum.
REQ-012 rd_data SHALL reflect a committed write starting in the COMMIT cycle; a read to the same address during GRANT SHALL return the old value.
REQ-013 Requesters SHALL hold req, address and data stable from assertion until ack; the block SHALL NOT sample req or wr_* in COMMIT.
REQ-014 Simultaneous requests SHALL be served strictly round-robin; a requester holding req continuously SHALL be served at most once per NREQ grants while others are requesting.
REQ-015 grant and ack SHALL never be high in the same cycle, and SHALL never have more than one bit set.
REQ-016 busy SHALL be 1 in GRANT and COMMIT, and 0 in IDLE.

Reset
REQ-017 While rst=1, the block SHALL hold: state=IDLE, rr_ptr=0, every bank entry=0, grant=0, ack=0, busy=0, wr_count=0.
REQ-018 rst asserted in GRANT or COMMIT SHALL abort the transaction immediately: no write, no ack.

Configuration
REQ-019 Macro LBA_STATS_EN defined:
- wr_count SHALL increment by 1 at each edge ending COMMIT;
- wr_count SHALL saturate at 255;
- aborted transactions per REQ-009 SHALL NOT be counted.
REQ-020 Macro LBA_STATS_EN undefined: the wr_count port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-021 Single write: req=0001, wr_addr0=2, data0=0xA5 -> grant=0001 for 1 cycle, then ack=0001 for 1 cycle, then rd_addr=2 reads 0xA5.
REQ-022 All requesters contend: req=1111 held, each data distinct, all to addr 1 -> grant order 0,1,2,3; final bank[1] = data3; 12 cycles total.
REQ-023 Wrap fairness: rr_ptr=3, req=1001 -> requester 3 granted first, then requester 0.
REQ-024 Abort: req[1] dropped during GRANT -> no ack, bank unchanged, rr_ptr unchanged, state returns to IDLE.
REQ-025 Async reset asserted mid-GRANT -> grant, ack and busy go 0 without a clock edge; all entries read 0.
REQ-026 With LBA_STATS_EN defined: 300 commits -> wr_count=255.
